// File: rtl/i2c_txn_sequencer.sv
// i2c_txn_sequencer: runs single-register writes and repeated-start register
// reads on an i2c_master, sharing it round-robin between two requesters and
// returning one response (read data or error code) per transaction.
// Optional macro I2C_SEQ_RETRY_EN: a NACKed transaction is restarted from its
// first step up to RETRY_MAX times before the NACK is reported.
module i2c_txn_sequencer #(
  parameter int TIMEOUT_CYC = 4096,
  parameter int RETRY_MAX   = 2
) (
  input  logic        i_clk,
  input  logic        reset_n,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [1:0]  req_rw,
  input  logic [13:0] req_dev,
  input  logic [15:0] req_reg,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [1:0]  rsp_err,
  output logic [7:0]  rsp_rdata,
  output logic [7:0]  m_addr_cmd_data,
  output logic        m_start,
  output logic        m_stop,
  output logic        m_rw_data,
  input  logic [3:0]  m_status,
  input  logic [7:0]  m_data
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_ACC, WAIT_DONE, ERR, RESP} state_t;

  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYC - 1);

  // m_status fields
  logic nack_addr, nack_data, tx_busy, data_ready;
  assign {nack_addr, nack_data, tx_busy, data_ready} = m_status;

  state_t      state, next_state;
  logic [1:0]  step, next_step;
  logic        last_grant, owner, grant, do_grant;
  logic        lat_rw;
  logic [6:0]  lat_dev;
  logic [7:0]  lat_reg, lat_wdata, rdata_q;
  logic [1:0]  err_q, err_code;
  logic [15:0] timer;
  logic        timer_clr, capture, set_err;
  logic [6:0]  gdev;
  logic [7:0]  greg, gwdata;
`ifdef I2C_SEQ_RETRY_EN
  logic [7:0]  retry_cnt;
  logic        retry;
`endif

  // Byte presented to the master for each step; STOP carries no byte.
  function automatic logic [7:0] step_byte(input logic rw, input logic [6:0] dev,
                                           input logic [7:0] rg, input logic [7:0] wd,
                                           input logic [1:0] st);
    case (st)
      2'd0:    step_byte = {dev, 1'b0};
      2'd1:    step_byte = rg;
      2'd2:    step_byte = rw ? {dev, 1'b1} : wd;
      default: step_byte = 8'h00;
    endcase
  endfunction

  assign gdev   = grant ? req_dev[13:7]    : req_dev[6:0];
  assign greg   = grant ? req_reg[15:8]    : req_reg[7:0];
  assign gwdata = grant ? req_wdata[15:8]  : req_wdata[7:0];

  // Strobes come straight from ISSUE so reset silences them immediately.
  assign m_start   = (state == ISSUE) && ((step == 2'd0) || ((step == 2'd2) && lat_rw));
  assign m_rw_data = (state == ISSUE) && ((step == 2'd1) || ((step == 2'd2) && !lat_rw));
  assign m_stop    = (state == ISSUE) && (step == 2'd3);
  assign rsp_valid = (state == RESP);

  // State and step register.
  always_ff @(posedge i_clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      step  <= 2'd0;
    end else begin
      state <= next_state;
      step  <= next_step;
    end
  end

  // Arbitration, step sequencing, status evaluation and timeout decisions.
  always_comb begin
    next_state = state;
    next_step  = step;
    grant      = 1'b0;
    do_grant   = 1'b0;
    timer_clr  = 1'b0;
    capture    = 1'b0;
    set_err    = 1'b0;
    err_code   = 2'd0;
`ifdef I2C_SEQ_RETRY_EN
    retry      = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (req_valid != 2'b00) begin
          do_grant   = 1'b1;
          grant      = (req_valid == 2'b11) ? ~last_grant : req_valid[1];
          next_state = ISSUE;
          next_step  = 2'd0;
        end
      end
      ISSUE: begin
        next_state = WAIT_ACC;
        timer_clr  = 1'b1;
      end
      WAIT_ACC: begin
        if (tx_busy) begin
          next_state = WAIT_DONE;
          timer_clr  = 1'b1;
        end else if (timer == TIMEOUT_LAST) begin
          next_state = ERR;
          set_err    = 1'b1;
          err_code   = 2'd3;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          if (nack_addr || nack_data) begin
            err_code = nack_addr ? 2'd1 : 2'd2;
`ifdef I2C_SEQ_RETRY_EN
            if (retry_cnt < 8'(RETRY_MAX)) begin
              retry      = 1'b1;
              next_state = ISSUE;
              next_step  = 2'd0;
            end else begin
              set_err    = 1'b1;
              next_state = ERR;
            end
`else
            set_err    = 1'b1;
            next_state = ERR;
`endif
          end else begin
            capture = lat_rw && (step == 2'd2) && data_ready;
            if (step == 2'd3) begin
              next_state = RESP;
            end else begin
              next_step  = step + 2'd1;
              next_state = ISSUE;
            end
          end
        end else if (timer == TIMEOUT_LAST) begin
          next_state = ERR;
          set_err    = 1'b1;
          err_code   = 2'd3;
        end
      end
      ERR:     next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Request latching, master byte, timer, read data, error and response registers.
  always_ff @(posedge i_clk or negedge reset_n) begin
    if (!reset_n) begin
      req_ready       <= 2'b00;
      last_grant      <= 1'b1;
      owner           <= 1'b0;
      lat_rw          <= 1'b0;
      lat_dev         <= 7'h00;
      lat_reg         <= 8'h00;
      lat_wdata       <= 8'h00;
      rdata_q         <= 8'h00;
      err_q           <= 2'd0;
      timer           <= 16'h0000;
      m_addr_cmd_data <= 8'h00;
      rsp_id          <= 1'b0;
      rsp_err         <= 2'd0;
      rsp_rdata       <= 8'h00;
`ifdef I2C_SEQ_RETRY_EN
      retry_cnt       <= 8'h00;
`endif
    end else begin
      req_ready <= 2'b00;
      if (do_grant) begin
        req_ready[grant] <= 1'b1;
        owner            <= grant;
        lat_rw           <= req_rw[grant];
        lat_dev          <= gdev;
        lat_reg          <= greg;
        lat_wdata        <= gwdata;
        rdata_q          <= 8'h00;
        err_q            <= 2'd0;
        m_addr_cmd_data  <= {gdev, 1'b0};
`ifdef I2C_SEQ_RETRY_EN
        retry_cnt        <= 8'h00;
`endif
      end else if ((next_state == ISSUE) && (next_step != 2'd3)) begin
        m_addr_cmd_data <= step_byte(lat_rw, lat_dev, lat_reg, lat_wdata, next_step);
      end
`ifdef I2C_SEQ_RETRY_EN
      if (retry) retry_cnt <= retry_cnt + 8'd1;
`endif
      if (timer_clr) timer <= 16'h0000;
      else if ((state == WAIT_ACC) || (state == WAIT_DONE)) timer <= timer + 16'd1;
      if (capture) rdata_q <= m_data;
      if (set_err) err_q <= err_code;
      if (next_state == RESP) begin
        rsp_id    <= owner;
        rsp_err   <= err_q;
        rsp_rdata <= ((err_q == 2'd0) && lat_rw) ? rdata_q : 8'h00;
      end
      if (state == RESP) last_grant <= owner;
    end
  end

endmodule

// File: tb/tb_i2c_txn_sequencer.sv
// Self-checking bench for i2c_txn_sequencer: a small i2c_master model answers
// the strobes, expected strobes/responses/grants are queued per scenario and
// compared with what the monitor observes.
module tb_i2c_txn_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_ready;
  logic [1:0]  req_rw = 2'b00;
  logic [13:0] req_dev = 14'h0;
  logic [15:0] req_reg = 16'h0;
  logic [15:0] req_wdata = 16'h0;
  logic        rsp_valid, rsp_id;
  logic [1:0]  rsp_err;
  logic [7:0]  rsp_rdata, m_addr_cmd_data;
  logic        m_start, m_stop, m_rw_data;
  logic [3:0]  m_status;
  logic [7:0]  m_data;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int start_cyc = 0;
  int rsp_cyc = 0;

  logic       slave_dead = 1'b0;
  logic       nack_en = 1'b0;
  logic [6:0] nack_dev = 7'h00;
  logic [7:0] read_byte = 8'h00;
  int         busy_cnt = 0;
  logic [3:0] pend = 4'h0;

  logic [9:0]  exp_s[$], obs_s[$];
  logic [10:0] exp_r[$], obs_r[$];
  logic [1:0]  exp_g[$], obs_g[$];

  i2c_txn_sequencer #(.TIMEOUT_CYC(16), .RETRY_MAX(2)) dut (
    .i_clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_dev(req_dev), .req_reg(req_reg), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .m_addr_cmd_data(m_addr_cmd_data), .m_start(m_start), .m_stop(m_stop),
    .m_rw_data(m_rw_data), .m_status(m_status), .m_data(m_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // i2c_master model: busy 3 cycles per command, then reports ACK/NACK/data.
  always @(negedge clk) begin
    if (!reset_n || slave_dead) begin
      m_status = 4'h0;
      m_data   = 8'h00;
      busy_cnt = 0;
    end else begin
      if (busy_cnt > 0) begin
        busy_cnt = busy_cnt - 1;
        if (busy_cnt == 0) m_status = pend;
      end
      if (m_start || m_rw_data || m_stop) begin
        pend = 4'h0;
        if (m_start && nack_en && (m_addr_cmd_data[7:1] == nack_dev)) pend[3] = 1'b1;
        if (m_start && m_addr_cmd_data[0]) begin
          pend[0] = 1'b1;
          m_data  = read_byte;
        end
        m_status = 4'b0010;
        busy_cnt = 3;
      end
    end
  end

  // Monitor: logs strobes, responses and grants as the DUT produces them.
  always @(negedge clk) begin
    if (reset_n) begin
      if (m_start) begin
        obs_s.push_back({2'd1, m_addr_cmd_data});
        start_cyc = cyc;
      end
      if (m_rw_data) obs_s.push_back({2'd2, m_addr_cmd_data});
      if (m_stop) obs_s.push_back({2'd3, 8'h00});
      if (rsp_valid) begin
        obs_r.push_back({rsp_id, rsp_err, rsp_rdata});
        rsp_cyc = cyc;
      end
      if (req_ready != 2'b00) obs_g.push_back(req_ready);
    end
  end

  task automatic clear_queues();
    exp_s.delete(); obs_s.delete();
    exp_r.delete(); obs_r.delete();
    exp_g.delete(); obs_g.delete();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset_n   = 1'b0;
    req_valid = 2'b00;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    clear_queues();
  endtask

  task automatic send(input int id, input logic rw, input logic [6:0] dev,
                      input logic [7:0] rg, input logic [7:0] wd);
    bit got;
    got = 1'b0;
    if (id == 1) begin
      req_rw[1] = rw; req_dev[13:7] = dev; req_reg[15:8] = rg; req_wdata[15:8] = wd;
    end else begin
      req_rw[0] = rw; req_dev[6:0] = dev; req_reg[7:0] = rg; req_wdata[7:0] = wd;
    end
    req_valid[id] = 1'b1;
    for (int c = 0; c < 50 && !got; c++) begin
      @(posedge clk); #1;
      if (req_ready[id]) got = 1'b1;
    end
    req_valid[id] = 1'b0;
    if (!got) begin
      total++; bad++;
      $display("[TB] FAIL grant_wait id=%0d got=no_ready exp=ready", id);
    end
  endtask

  task automatic wait_rsp(input int n);
    for (int c = 0; c < 300 && obs_r.size() < n; c++) @(posedge clk);
    @(posedge clk); #1;
    if (obs_r.size() < n) begin
      total++; bad++;
      $display("[TB] FAIL rsp_wait got=%0d exp=%0d", obs_r.size(), n);
    end
  endtask

  task automatic test_reset();
    #2;
    reset_n   = 1'b0;
    req_valid = 2'b11;
    repeat (3) @(posedge clk);
    #1;
    total++; if (req_ready !== 2'b00) begin bad++; $display("[TB] FAIL reset_req_ready got=%b exp=00", req_ready); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    total++; if ({rsp_id, rsp_err, rsp_rdata} !== 11'h0) begin bad++; $display("[TB] FAIL reset_rsp got=%h exp=0", {rsp_id, rsp_err, rsp_rdata}); end
    total++; if ({m_start, m_stop, m_rw_data} !== 3'b000) begin bad++; $display("[TB] FAIL reset_strobes got=%b exp=000", {m_start, m_stop, m_rw_data}); end
    total++; if (m_addr_cmd_data !== 8'h00) begin bad++; $display("[TB] FAIL reset_byte got=%h exp=00", m_addr_cmd_data); end
    req_valid = 2'b00;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (obs_g.size() !== 0) begin bad++; $display("[TB] FAIL reset_no_grant got=%0d exp=0", obs_g.size()); end
    clear_queues();
  endtask

  task automatic test_write();
    logic [9:0] e, o;
    logic [10:0] er, orr;
    exp_s.push_back({2'd1, 8'hA0}); exp_s.push_back({2'd2, 8'h10});
    exp_s.push_back({2'd2, 8'hA5}); exp_s.push_back({2'd3, 8'h00});
    exp_r.push_back({1'b0, 2'd0, 8'h00});
    send(0, 1'b0, 7'h50, 8'h10, 8'hA5);
    wait_rsp(1);
    total++; if (obs_s.size() !== exp_s.size()) begin bad++; $display("[TB] FAIL write_strobe_count got=%0d exp=%0d", obs_s.size(), exp_s.size()); end
    while (exp_s.size() > 0 && obs_s.size() > 0) begin
      e = exp_s.pop_front(); o = obs_s.pop_front(); total++;
      if (o !== e) begin bad++; $display("[TB] FAIL write_strobe got=%h exp=%h", o, e); end
    end
    while (exp_r.size() > 0 && obs_r.size() > 0) begin
      er = exp_r.pop_front(); orr = obs_r.pop_front(); total++;
      if (orr !== er) begin bad++; $display("[TB] FAIL write_rsp got=%h exp=%h", orr, er); end
    end
    clear_queues();
  endtask

  task automatic test_read();
    logic [9:0] e, o;
    logic [10:0] er, orr;
    read_byte = 8'h3C;
    exp_s.push_back({2'd1, 8'hD0}); exp_s.push_back({2'd2, 8'h75});
    exp_s.push_back({2'd1, 8'hD1}); exp_s.push_back({2'd3, 8'h00});
    exp_r.push_back({1'b1, 2'd0, 8'h3C});
    send(1, 1'b1, 7'h68, 8'h75, 8'h00);
    wait_rsp(1);
    total++; if (obs_s.size() !== exp_s.size()) begin bad++; $display("[TB] FAIL read_strobe_count got=%0d exp=%0d", obs_s.size(), exp_s.size()); end
    while (exp_s.size() > 0 && obs_s.size() > 0) begin
      e = exp_s.pop_front(); o = obs_s.pop_front(); total++;
      if (o !== e) begin bad++; $display("[TB] FAIL read_strobe got=%h exp=%h", o, e); end
    end
    while (exp_r.size() > 0 && obs_r.size() > 0) begin
      er = exp_r.pop_front(); orr = obs_r.pop_front(); total++;
      if (orr !== er) begin bad++; $display("[TB] FAIL read_rsp got=%h exp=%h", orr, er); end
    end
    clear_queues();
  endtask

  task automatic test_back_to_back();
    int g0;
    logic [1:0] eg, og;
    logic [10:0] er, orr;
    apply_reset();
    exp_g.push_back(2'b01); exp_g.push_back(2'b10); exp_g.push_back(2'b01);
    exp_r.push_back({1'b0, 2'd0, 8'h00}); exp_r.push_back({1'b1, 2'd0, 8'h00});
    exp_r.push_back({1'b0, 2'd0, 8'h00});
    req_rw = 2'b00; req_dev = {7'h51, 7'h50};
    req_reg = {8'h21, 8'h20}; req_wdata = {8'h02, 8'h01};
    req_valid = 2'b11;
    g0 = 0;
    for (int c = 0; c < 600 && obs_r.size() < 3; c++) begin
      @(posedge clk); #1;
      if (req_ready[1]) req_valid[1] = 1'b0;
      if (req_ready[0]) begin
        g0++;
        if (g0 == 2) req_valid[0] = 1'b0;
      end
    end
    req_valid = 2'b00;
    repeat (20) @(posedge clk);
    #1;
    total++; if (obs_g.size() !== 3) begin bad++; $display("[TB] FAIL arb_grant_count got=%0d exp=3", obs_g.size()); end
    total++; if (obs_r.size() !== 3) begin bad++; $display("[TB] FAIL arb_rsp_count got=%0d exp=3", obs_r.size()); end
    while (exp_g.size() > 0 && obs_g.size() > 0) begin
      eg = exp_g.pop_front(); og = obs_g.pop_front(); total++;
      if (og !== eg) begin bad++; $display("[TB] FAIL arb_grant got=%b exp=%b", og, eg); end
    end
    while (exp_r.size() > 0 && obs_r.size() > 0) begin
      er = exp_r.pop_front(); orr = obs_r.pop_front(); total++;
      if (orr !== er) begin bad++; $display("[TB] FAIL arb_rsp got=%h exp=%h", orr, er); end
    end
    clear_queues();
  endtask

  task automatic test_nack();
    logic [9:0] e, o;
    logic [10:0] er, orr;
    nack_en  = 1'b1;
    nack_dev = 7'h22;
    read_byte = 8'h99;
    exp_s.push_back({2'd1, 8'h44});
`ifdef I2C_SEQ_RETRY_EN
    exp_s.push_back({2'd1, 8'h44});
    exp_s.push_back({2'd1, 8'h44});
`endif
    exp_r.push_back({1'b0, 2'd1, 8'h00});
    send(0, 1'b1, 7'h22, 8'h05, 8'h00);
    wait_rsp(1);
    total++; if (obs_s.size() !== exp_s.size()) begin bad++; $display("[TB] FAIL nack_strobe_count got=%0d exp=%0d", obs_s.size(), exp_s.size()); end
    while (exp_s.size() > 0 && obs_s.size() > 0) begin
      e = exp_s.pop_front(); o = obs_s.pop_front(); total++;
      if (o !== e) begin bad++; $display("[TB] FAIL nack_strobe got=%h exp=%h", o, e); end
    end
    while (exp_r.size() > 0 && obs_r.size() > 0) begin
      er = exp_r.pop_front(); orr = obs_r.pop_front(); total++;
      if (orr !== er) begin bad++; $display("[TB] FAIL nack_rsp got=%h exp=%h", orr, er); end
    end
    nack_en = 1'b0;
    clear_queues();
  endtask

  task automatic test_timeout();
    int d;
    logic [10:0] er, orr;
    slave_dead = 1'b1;
    exp_r.push_back({1'b1, 2'd3, 8'h00});
    send(1, 1'b0, 7'h50, 8'h11, 8'h22);
    wait_rsp(1);
    d = rsp_cyc - start_cyc;
    total++; if (d < 17 || d > 18) begin bad++; $display("[TB] FAIL timeout_latency got=%0d exp=17..18", d); end
    total++; if (obs_s.size() !== 1) begin bad++; $display("[TB] FAIL timeout_strobe_count got=%0d exp=1", obs_s.size()); end
    while (exp_r.size() > 0 && obs_r.size() > 0) begin
      er = exp_r.pop_front(); orr = obs_r.pop_front(); total++;
      if (orr !== er) begin bad++; $display("[TB] FAIL timeout_rsp got=%h exp=%h", orr, er); end
    end
    clear_queues();
    slave_dead = 1'b0;
    exp_r.push_back({1'b0, 2'd0, 8'h00});
    send(0, 1'b0, 7'h50, 8'h12, 8'h34);
    wait_rsp(1);
    while (exp_r.size() > 0 && obs_r.size() > 0) begin
      er = exp_r.pop_front(); orr = obs_r.pop_front(); total++;
      if (orr !== er) begin bad++; $display("[TB] FAIL post_timeout_rsp got=%h exp=%h", orr, er); end
    end
    clear_queues();
  endtask

  task automatic test_reset_mid_read();
    logic [10:0] er, orr;
    read_byte = 8'h3C;
    send(1, 1'b1, 7'h68, 8'h75, 8'h00);
    for (int c = 0; c < 100 && obs_s.size() < 2; c++) begin
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    total++; if ({m_start, m_stop, m_rw_data, rsp_valid} !== 4'b0000) begin bad++; $display("[TB] FAIL midreset_strobes got=%b exp=0000", {m_start, m_stop, m_rw_data, rsp_valid}); end
    total++; if ({req_ready, m_addr_cmd_data, rsp_id, rsp_err, rsp_rdata} !== 21'h0) begin bad++; $display("[TB] FAIL midreset_regs got=%h exp=0", {req_ready, m_addr_cmd_data, rsp_id, rsp_err, rsp_rdata}); end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    total++; if (obs_r.size() !== 0) begin bad++; $display("[TB] FAIL midreset_no_rsp got=%0d exp=0", obs_r.size()); end
    clear_queues();
    read_byte = 8'h5A;
    exp_r.push_back({1'b0, 2'd0, 8'h5A});
    send(0, 1'b1, 7'h68, 8'h76, 8'h00);
    wait_rsp(1);
    total++; if (obs_s.size() !== 4) begin bad++; $display("[TB] FAIL postreset_strobe_count got=%0d exp=4", obs_s.size()); end
    while (exp_r.size() > 0 && obs_r.size() > 0) begin
      er = exp_r.pop_front(); orr = obs_r.pop_front(); total++;
      if (orr !== er) begin bad++; $display("[TB] FAIL postreset_rsp got=%h exp=%h", orr, er); end
    end
    clear_queues();
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_nack();
    test_timeout();
    test_reset_mid_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
